alu_arbiter: RTL

- Shares one combinational 32-bit ALU (4-bit ALUCtrl encoding below) between two requesters, e.g. the integer pipeline and a multi-cycle helper unit.
- Arbitrates round-robin, registers the winner's operands and drives the shared ALU from those registers.
- Captures BusW/Zero into a response register with a one-deep valid/ready response channel.
- Sits between requesters and the single ALU instance; the ALU itself stays outside this block.

---
 rtl/alu_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Winner's operands are registered onto the ALU bus; the result returns on a one-deep valid/ready channel.
module alu_arbiter #(
    parameter int W  = 32,
    parameter int CW = 4
) (
    input  logic          CLK,
    input  logic          Reset_L,
    input  logic [1:0]    ReqValid,
    output logic [1:0]    ReqReady,
    input  logic [W-1:0]  ReqA0,
    input  logic [W-1:0]  ReqB0,
    input  logic [CW-1:0] ReqCtrl0,
    input  logic [W-1:0]  ReqA1,
    input  logic [W-1:0]  ReqB1,
    input  logic [CW-1:0] ReqCtrl1,
    output logic [W-1:0]  AluBusA,
    output logic [W-1:0]  AluBusB,
    output logic [CW-1:0] AluCtrl,
    input  logic [W-1:0]  AluBusW,
    input  logic          AluZero,
    output logic          RspValid,
    input  logic          RspReady,
    output logic          RspId,
    output logic [W-1:0]  RspData,
    output logic          RspZero,
    output logic          RspErr,
    output logic          Busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          last_grant_q;
    logic          grant;
    logic          accept;
    logic [W-1:0]  bus_a_q, bus_b_q;
    logic [CW-1:0] ctrl_q;
    logic          err_q;
    logic          rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_err_q;
    logic [W-1:0]  rsp_data_q;
    logic [CW-1:0] sel_ctrl;

    function automatic logic is_undef(input logic [CW-1:0] c);
        return (c == CW'(4'b0101)) || (c == CW'(4'b1111));
    endfunction

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant = 1'b0;
        case (ReqValid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
    end

    assign sel_ctrl = grant ? ReqCtrl1 : ReqCtrl0;

    always_comb begin
        state_d  = state_q;
        ReqReady = 2'b00;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|ReqValid) begin
                    ReqReady = grant ? 2'b10 : 2'b01;
                    accept   = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (RspReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            last_grant_q <= 1'b1;
            bus_a_q      <= '0;
            bus_b_q      <= '0;
            ctrl_q       <= '0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (accept) begin
                bus_a_q      <= grant ? ReqA1 : ReqA0;
                bus_b_q      <= grant ? ReqB1 : ReqB0;
                ctrl_q       <= sel_ctrl;
                err_q        <= is_undef(sel_ctrl);
                rsp_id_q     <= grant;
                last_grant_q <= grant;
            end
            if (state_q == EXEC) begin
                rsp_data_q  <= AluBusW;
                rsp_zero_q  <= AluZero;
                rsp_err_q   <= err_q;
                rsp_valid_q <= 1'b1;
            end
            if (state_q == RESP && RspReady) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign AluBusA  = bus_a_q;
    assign AluBusB  = bus_b_q;
    assign AluCtrl  = ctrl_q;
    assign RspValid = rsp_valid_q;
    assign RspId    = rsp_id_q;
    assign RspData  = rsp_data_q;
    assign RspZero  = rsp_zero_q;
    assign RspErr   = rsp_err_q;
    assign Busy     = (state_q != IDLE);

endmodule
